// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I control for a 5-stage pipeline.
// Decodes the ID instruction into a control word, carries it through the
// ID/EX, EX/MEM and MEM/WB registers, resolves PC redirection in EX, and
// raises the load-use stall and the taken-branch/jump flush.
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUCTRL_W  = 4,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_i,
  input  logic                  id_valid_i,
  input  logic                  branch_decision_i,
  output logic [2:0]            id_imm_src_o,
  output logic [ALUCTRL_W-1:0]  ex_alu_ctrl_o,
  output logic                  ex_alusrca_o,
  output logic                  ex_alusrcb_o,
  output logic                  ex_pcadd_srca_o,
  output logic                  ex_pcadd_srcb_o,
  output logic                  pc_src_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  output logic                  wb_reg_write_o,
  output logic [1:0]            wb_result_src_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  ex_illegal_o
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_PASS = 4'd10
  } alu_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_e;

  // Control word carried down the pipe; all-zero is the bubble.
  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic                  jump;
    logic [ALUCTRL_W-1:0]  alu_ctrl;
    logic                  alusrca;
    logic                  alusrcb;
    logic                  pcadd_srca;
    logic                  pcadd_srcb;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Shared by R-type and I-type ALU ops; SUB exists only for R-type.
  function automatic logic [ALUCTRL_W-1:0] alu_code(input logic [2:0] f3,
                                                    input logic       f7b5,
                                                    input logic       is_r);
    alu_e op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return ALUCTRL_W'(op);
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7b5 = instr_i[30];
  assign rs1      = REG_ADDR_W'(instr_i[19:15]);
  assign rs2      = REG_ADDR_W'(instr_i[24:20]);
  assign rd       = REG_ADDR_W'(instr_i[11:7]);

  ctrl_t id_word;
  logic  uses_rs1;
  logic  uses_rs2;
  logic  known;
  logic [2:0] imm_src;

  // ID-stage decode of the instruction into a control word.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    id_word  = BUBBLE;
    imm_src  = IMM_I;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    known    = 1'b1;
    case (opcode)
      OP_R: begin
        id_word.reg_write = 1'b1;
        id_word.alu_ctrl  = alu_code(funct3, funct7b5, 1'b1);
        id_word.rd        = rd;
        uses_rs1          = 1'b1;
        uses_rs2          = 1'b1;
      end
      OP_I: begin
        id_word.reg_write = 1'b1;
        id_word.alu_ctrl  = alu_code(funct3, funct7b5, 1'b0);
        id_word.alusrcb   = 1'b1;
        id_word.rd        = rd;
        uses_rs1          = 1'b1;
      end
      OP_LOAD: begin
        id_word.reg_write  = 1'b1;
        id_word.result_src = 2'b01;
        id_word.mem_read   = 1'b1;
        id_word.alusrcb    = 1'b1;
        id_word.rd         = rd;
        uses_rs1           = 1'b1;
      end
      OP_STORE: begin
        id_word.mem_write = 1'b1;
        id_word.alusrcb   = 1'b1;
        imm_src           = IMM_S;
        uses_rs1          = 1'b1;
        uses_rs2          = 1'b1;
      end
      OP_BRANCH: begin
        id_word.branch   = 1'b1;
        id_word.alu_ctrl = ALUCTRL_W'(ALU_SUB);
        imm_src          = IMM_B;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
      end
      OP_JAL: begin
        id_word.reg_write  = 1'b1;
        id_word.result_src = 2'b10;
        id_word.jump       = 1'b1;
        id_word.alusrca    = 1'b1;
        id_word.alusrcb    = 1'b1;
        id_word.rd         = rd;
        imm_src            = IMM_J;
      end
      OP_JALR: begin
        id_word.reg_write  = 1'b1;
        id_word.result_src = 2'b10;
        id_word.jump       = 1'b1;
        id_word.alusrcb    = 1'b1;
        id_word.pcadd_srca = 1'b1;
        id_word.rd         = rd;
        uses_rs1           = 1'b1;
      end
      OP_LUI: begin
        id_word.reg_write = 1'b1;
        id_word.alu_ctrl  = ALUCTRL_W'(ALU_PASS);
        id_word.alusrcb   = 1'b1;
        id_word.rd        = rd;
        imm_src           = IMM_U;
      end
      OP_AUIPC: begin
        id_word.reg_write = 1'b1;
        id_word.alusrca   = 1'b1;
        id_word.alusrcb   = 1'b1;
        id_word.rd        = rd;
        imm_src           = IMM_U;
      end
      default: known = 1'b0;
    endcase
    if (!known || !id_valid_i) begin
      id_word         = BUBBLE;
      id_word.illegal = !known && id_valid_i;
    end
    // x0 is never written.
    if (id_word.rd == '0) id_word.reg_write = 1'b0;
  end

  ctrl_t idex_q, exmem_q, memwb_q;
  logic  stall_raw;

  assign pc_src_o = (idex_q.branch & branch_decision_i) | idex_q.jump;
  assign flush_o  = pc_src_o;

  assign stall_raw = HAZARD_EN && idex_q.mem_read && (idex_q.rd != '0) && id_valid_i &&
                     (((idex_q.rd == rs1) && uses_rs1) || ((idex_q.rd == rs2) && uses_rs2));
  // Flush wins: a squashed ID slot has nothing to wait for.
  assign stall_o   = stall_raw & ~pc_src_o;

  // Pipeline registers: ID/EX inserts a bubble on flush or stall, later stages always advance.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
    if (reset) begin
      idex_q  <= BUBBLE;
      exmem_q <= BUBBLE;
      memwb_q <= BUBBLE;
    end else begin
      idex_q  <= (flush_o || stall_o) ? BUBBLE : id_word;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
    end
  end

  assign id_imm_src_o    = imm_src;
  assign ex_alu_ctrl_o   = idex_q.alu_ctrl;
  assign ex_alusrca_o    = idex_q.alusrca;
  assign ex_alusrcb_o    = idex_q.alusrcb;
  assign ex_pcadd_srca_o = idex_q.pcadd_srca;
  assign ex_pcadd_srcb_o = idex_q.pcadd_srcb;
  assign ex_illegal_o    = idex_q.illegal;
  assign mem_write_o     = exmem_q.mem_write;
  assign mem_read_o      = exmem_q.mem_read;
  assign wb_reg_write_o  = memwb_q.reg_write;
  assign wb_result_src_o = memwb_q.result_src;
  assign wb_rd_o         = memwb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: two instances share the stimulus,
// one with the load-use interlock and one without.
module tb_pipelined_control_unit;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD60 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_BEQ   = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_JALR  = 32'h000100E7; // jalr x1,0(x2)
  localparam logic [31:0] I_ILL   = 32'h0000007F; // opcode 1111111
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_SRA   = 32'h4020D1B3; // sra  x3,x1,x2
  localparam logic [31:0] I_SRAI  = 32'h4020D193; // srai x3,x1,2
  localparam logic [31:0] I_SRLI  = 32'h0020D193; // srli x3,x1,2
  localparam logic [31:0] I_LUI   = 32'h000011B7; // lui  x3,1
  localparam logic [31:0] I_SW    = 32'h0020A023; // sw   x2,0(x1)

  logic        clk;
  logic        reset;
  logic [31:0] instr_i;
  logic        id_valid_i;
  logic        branch_decision_i;

  logic [2:0] imm_src, nh_imm_src;
  logic [3:0] alu_ctrl, nh_alu_ctrl;
  logic       alusrca, alusrcb, pcadd_a, pcadd_b, pc_src, stall, flush;
  logic       mem_write, mem_read, wb_rw, illegal;
  logic [1:0] wb_rs;
  logic [4:0] wb_rd;
  logic       nh_alusrca, nh_alusrcb, nh_pcadd_a, nh_pcadd_b, nh_pc_src, nh_stall, nh_flush;
  logic       nh_mem_write, nh_mem_read, nh_wb_rw, nh_illegal;
  logic [1:0] nh_wb_rs;
  logic [4:0] nh_wb_rd;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUCTRL_W(4), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .id_valid_i(id_valid_i),
    .branch_decision_i(branch_decision_i), .id_imm_src_o(imm_src), .ex_alu_ctrl_o(alu_ctrl),
    .ex_alusrca_o(alusrca), .ex_alusrcb_o(alusrcb), .ex_pcadd_srca_o(pcadd_a),
    .ex_pcadd_srcb_o(pcadd_b), .pc_src_o(pc_src), .stall_o(stall), .flush_o(flush),
    .mem_write_o(mem_write), .mem_read_o(mem_read), .wb_reg_write_o(wb_rw),
    .wb_result_src_o(wb_rs), .wb_rd_o(wb_rd), .ex_illegal_o(illegal)
  );

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUCTRL_W(4), .HAZARD_EN(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .instr_i(instr_i), .id_valid_i(id_valid_i),
    .branch_decision_i(branch_decision_i), .id_imm_src_o(nh_imm_src), .ex_alu_ctrl_o(nh_alu_ctrl),
    .ex_alusrca_o(nh_alusrca), .ex_alusrcb_o(nh_alusrcb), .ex_pcadd_srca_o(nh_pcadd_a),
    .ex_pcadd_srcb_o(nh_pcadd_b), .pc_src_o(nh_pc_src), .stall_o(nh_stall), .flush_o(nh_flush),
    .mem_write_o(nh_mem_write), .mem_read_o(nh_mem_read), .wb_reg_write_o(nh_wb_rw),
    .wb_result_src_o(nh_wb_rs), .wb_rd_o(nh_wb_rd), .ex_illegal_o(nh_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one ID slot mid-cycle; outputs are then sampled 1 time unit later.
  task automatic cyc(input logic [31:0] ins, input logic vld, input logic dec);
    @(negedge clk);
    instr_i           = ins;
    id_valid_i        = vld;
    branch_decision_i = dec;
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    instr_i           = '0;
    id_valid_i        = 1'b0;
    branch_decision_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu",    alu_ctrl, 0);
    check("rst_alusrcb", alusrcb, 0);
    check("rst_pc_src", pc_src, 0);
    check("rst_stall",  stall, 0);
    check("rst_wb_rw",  wb_rw, 0);
    check("rst_wb_rd",  wb_rd, 0);
    @(negedge clk);
    reset = 1'b0;

    // add x3,x1,x2 reaches WB three cycles after ID
    cyc(I_ADD, 1, 0);
    check("add_imm_src", imm_src, 0);
    cyc(0, 0, 0);
    check("add_ex_alu", alu_ctrl, 0);
    check("add_ex_srcb", alusrcb, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("add_wb_rw", wb_rw, 1);
    check("add_wb_rd", wb_rd, 3);
    check("add_wb_rs", wb_rs, 0);

    // asynchronous reset with a jump sitting in EX
    cyc(I_JALR, 1, 0);
    cyc(0, 0, 0);
    check("pre_rst_pc_src", pc_src, 1);
    reset = 1'b1;
    #1;
    check("arst_pc_src", pc_src, 0);
    check("arst_flush", flush, 0);
    check("arst_pcadd_a", pcadd_a, 0);
    check("arst_srcb", alusrcb, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(I_ADD, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("post_rst_wb_rw", wb_rw, 1);
    check("post_rst_wb_rd", wb_rd, 3);

    // load-use: lw x5 then add x6,x5,x2
    cyc(I_LW5, 1, 0);
    cyc(I_ADD6, 1, 0);
    check("lu_stall", stall, 1);
    check("lu_nh_stall", nh_stall, 0);
    cyc(I_ADD6, 1, 0);
    check("lu_stall_once", stall, 0);
    check("lu_ex_bubble", alusrcb, 0);
    check("lu_mem_read", mem_read, 1);
    cyc(0, 0, 0);
    check("lu_wb_rs_load", wb_rs, 1);
    check("lu_wb_rd_load", wb_rd, 5);
    cyc(0, 0, 0);
    check("lu_mem_bubble", mem_read, 0);
    check("lu_wb_bubble", wb_rw, 0);
    cyc(0, 0, 0);
    check("lu_wb_rd_add", wb_rd, 6);
    check("lu_wb_rw_add", wb_rw, 1);

    // x0 destination never interlocks and never writes
    cyc(I_LW0, 1, 0);
    cyc(I_ADD60, 1, 0);
    check("x0_stall", stall, 0);
    cyc(0, 0, 0);
    check("x0_mem_read", mem_read, 1);
    cyc(0, 0, 0);
    check("x0_wb_rw", wb_rw, 0);
    check("x0_wb_rd", wb_rd, 0);

    // taken branch squashes the following ID slot
    cyc(I_BEQ, 1, 0);
    check("beq_imm_src", imm_src, 3'b010);
    cyc(I_LW5, 1, 1);
    check("beq_pc_src", pc_src, 1);
    check("beq_flush", flush, 1);
    check("beq_ex_alu", alu_ctrl, 1);
    cyc(0, 0, 0);
    check("beq_ex_squashed", alusrcb, 0);
    check("beq_pc_src_after", pc_src, 0);
    // not-taken branch lets it through
    cyc(I_BEQ, 1, 0);
    cyc(I_LW5, 1, 0);
    check("bnt_pc_src", pc_src, 0);
    check("bnt_flush", flush, 0);
    cyc(0, 0, 0);
    check("bnt_ex_load", alusrcb, 1);

    // jalr x1,0(x2)
    cyc(I_JALR, 1, 0);
    check("jalr_imm_src", imm_src, 0);
    cyc(0, 0, 0);
    check("jalr_pc_src", pc_src, 1);
    check("jalr_pcadd_a", pcadd_a, 1);
    check("jalr_pcadd_b", pcadd_b, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("jalr_wb_rs", wb_rs, 2);
    check("jalr_wb_rd", wb_rd, 1);
    check("jalr_wb_rw", wb_rw, 1);

    // undecodable opcode, valid and invalid
    cyc(I_ILL, 1, 0);
    cyc(I_ILL, 0, 0);
    check("ill_flag", illegal, 1);
    check("ill_srcb", alusrcb, 0);
    cyc(0, 0, 0);
    check("ill_invalid_flag", illegal, 0);
    check("ill_mem_write", mem_write, 0);
    check("ill_mem_read", mem_read, 0);

    // ALU code selection
    cyc(I_SUB, 1, 0);
    cyc(I_SRA, 1, 0);
    check("sub_alu", alu_ctrl, 1);
    cyc(I_SRAI, 1, 0);
    check("sra_alu", alu_ctrl, 9);
    cyc(I_SRLI, 1, 0);
    check("srai_alu", alu_ctrl, 9);
    check("srai_srcb", alusrcb, 1);
    cyc(I_LUI, 1, 0);
    check("srli_alu", alu_ctrl, 8);
    check("lui_imm_src", imm_src, 3'b100);
    cyc(I_SW, 1, 0);
    check("lui_alu", alu_ctrl, 10);
    check("sw_imm_src", imm_src, 3'b001);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("sw_mem_write", mem_write, 1);
    cyc(0, 0, 0);
    check("sw_wb_rw", wb_rw, 0);
    check("sw_wb_rd", wb_rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
